// File: rtl/hwpe_ctrl_ucode_sched_if.sv
// Control/handoff bundle between the ucode sequencer, the offset engine and the streamers.
// The master view is the sequencer; the slave view is the environment driving it.
interface hwpe_ctrl_ucode_sched_if #(
  parameter int NB_ITER_W = 16
);
  logic                 start_i;
  logic                 abort_i;
  logic                 ucode_valid_i;
  logic                 ucode_done_i;
  logic                 ucode_accum_i;
  logic                 ucode_enable_o;
  logic                 ucode_clear_o;
  logic                 upd_valid_o;
  logic                 upd_ready_i;
  logic                 upd_accum_o;
  logic                 upd_last_o;
  logic                 busy_o;
  logic                 evt_done_o;
  logic                 err_o;
  logic [NB_ITER_W-1:0] iter_cnt_o;

  modport master (
    input  start_i, abort_i, ucode_valid_i, ucode_done_i, ucode_accum_i, upd_ready_i,
    output ucode_enable_o, ucode_clear_o, upd_valid_o, upd_accum_o, upd_last_o,
           busy_o, evt_done_o, err_o, iter_cnt_o
  );

  modport slave (
    output start_i, abort_i, ucode_valid_i, ucode_done_i, ucode_accum_i, upd_ready_i,
    input  ucode_enable_o, ucode_clear_o, upd_valid_o, upd_accum_o, upd_last_o,
           busy_o, evt_done_o, err_o, iter_cnt_o
  );
endinterface

// File: rtl/hwpe_ctrl_ucode_sched.sv
// Sequencer for the HWPE microcode offset engine: clears it on job start, steps it per
// iteration, hands each offset update to the streamers and signals job completion.
module hwpe_ctrl_ucode_sched #(
  parameter int NB_ITER_W = 16,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hwpe_ctrl_ucode_sched_if.master bus,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    HANDOFF = 3'd3,
    FINISH  = 3'd4
  } state_e;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [NB_ITER_W-1:0] iter_q, iter_d;
  logic                 done_seen_q, done_seen_d;
  logic                 err_q, err_d;
  logic                 accum_q, accum_d;
  logic                 last_q, last_d;
  logic                 clear_q, clear_d;
  logic                 upd_valid_q, upd_valid_d;
  logic                 evt_q, evt_d;
  logic                 kill;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      step_q      <= '0;
      iter_q      <= '0;
      done_seen_q <= 1'b0;
      err_q       <= 1'b0;
      accum_q     <= 1'b0;
      last_q      <= 1'b0;
      clear_q     <= 1'b0;
      upd_valid_q <= 1'b0;
      evt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      iter_q      <= iter_d;
      done_seen_q <= done_seen_d;
      err_q       <= err_d;
      accum_q     <= accum_d;
      last_q      <= last_d;
      clear_q     <= clear_d;
      upd_valid_q <= upd_valid_d;
      evt_q       <= evt_d;
    end
  end

  // Update handshake: upd_valid_o rises one cycle after the engine's valid flag and,
  // together with upd_accum_o/upd_last_o, holds until the cycle upd_ready_i is sampled
  // high; only abort or reset may withdraw it early.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    iter_d      = iter_q;
    done_seen_d = done_seen_q;
    err_d       = err_q;
    accum_d     = accum_q;
    last_d      = last_q;
    kill        = 1'b0;

    if (state_q != IDLE && bus.abort_i) begin
      state_d = IDLE;
      kill    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_d     = CLEAR;
            step_d      = '0;
            iter_d      = '0;
            err_d       = 1'b0;
            done_seen_d = 1'b0;
          end
        end
        CLEAR: begin
          state_d = RUN;
          step_d  = '0;
        end
        RUN: begin
          // The engine's done pulse may lead its valid pulse by a cycle.
          done_seen_d = done_seen_q | bus.ucode_done_i;
          if (bus.ucode_valid_i) begin
            state_d = HANDOFF;
            accum_d = bus.ucode_accum_i;
            last_d  = done_seen_q | bus.ucode_done_i;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            kill    = 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        HANDOFF: begin
          if (bus.upd_ready_i) begin
            if (iter_q != '1) iter_d = iter_q + 1'b1;
            state_d = done_seen_q ? FINISH : RUN;
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    clear_d     = kill | (state_d == CLEAR) | (state_d == FINISH);
    upd_valid_d = (state_d == HANDOFF);
    evt_d       = (state_d == FINISH);
    if (state_d != HANDOFF) begin
      accum_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Enable is the only decoded output so the engine stays put on its own valid cycle.
  assign bus.ucode_enable_o = (state_q == RUN) & ~bus.ucode_valid_i;
  assign bus.ucode_clear_o  = clear_q;
  assign bus.upd_valid_o    = upd_valid_q;
  assign bus.upd_accum_o    = accum_q;
  assign bus.upd_last_o     = last_q;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.evt_done_o     = evt_q;
  assign bus.err_o          = err_q;
  assign bus.iter_cnt_o     = iter_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_hwpe_ctrl_ucode_sched.sv
// Directed bench for hwpe_ctrl_ucode_sched: multi-iteration job, backpressure, watchdog,
// abort, start/abort priority and mid-job reset, with hand-computed expectations.
module tb_hwpe_ctrl_ucode_sched;

  localparam int NB_ITER_W = 16;

  localparam logic [7:0] EN  = 8'h80;
  localparam logic [7:0] CLR = 8'h40;
  localparam logic [7:0] UV  = 8'h20;
  localparam logic [7:0] ACC = 8'h10;
  localparam logic [7:0] LST = 8'h08;
  localparam logic [7:0] BSY = 8'h04;
  localparam logic [7:0] EVT = 8'h02;
  localparam logic [7:0] ERR = 8'h01;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;

  hwpe_ctrl_ucode_sched_if #(.NB_ITER_W(NB_ITER_W)) bus ();

  hwpe_ctrl_ucode_sched #(
    .NB_ITER_W(NB_ITER_W),
    .STEP_W   (8),
    .MAX_STEPS(8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.ucode_enable_o, bus.ucode_clear_o, bus.upd_valid_o, bus.upd_accum_o,
            bus.upd_last_o, bus.busy_o, bus.evt_done_o, bus.err_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Entered with the DUT in RUN right after an edge; leaves it just after the ready edge.
  task automatic run_iter(input int n_en, input bit acc, input bit dn_early, input bit dn,
                          input int stall, input bit exp_last, input int exp_iter);
    logic [7:0] hexp;
    for (int i = 0; i < n_en; i++) begin
      if (dn_early && i == n_en - 1) bus.ucode_done_i = 1'b1;
      #1;
      chk("run_enable", outs(), EN | BSY);
      tick();
      bus.ucode_done_i = 1'b0;
    end
    bus.ucode_valid_i = 1'b1;
    bus.ucode_accum_i = acc;
    bus.ucode_done_i  = dn;
    if (stall > 0) bus.upd_ready_i = 1'b0;
    #1;
    chk("valid_cycle_frozen", outs(), BSY);
    tick();
    bus.ucode_valid_i = 1'b0;
    bus.ucode_accum_i = 1'b0;
    bus.ucode_done_i  = 1'b0;
    hexp = UV | BSY | (acc ? ACC : 8'h00) | (exp_last ? LST : 8'h00);
    for (int i = 0; i < stall; i++) begin
      chk("stall_outs", outs(), hexp);
      chk("stall_iter", bus.iter_cnt_o, exp_iter);
      tick();
    end
    bus.upd_ready_i = 1'b1;
    #1;
    chk("handoff_outs", outs(), hexp);
    chk("handoff_iter", bus.iter_cnt_o, exp_iter);
    tick();
    chk("iter_after_ready", bus.iter_cnt_o, exp_iter + 1);
  endtask

  task automatic start_job();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("clear_state", outs(), CLR | BSY);
    chk("clear_iter", bus.iter_cnt_o, 0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start_i       = 1'b0;
    bus.abort_i       = 1'b0;
    bus.ucode_valid_i = 1'b0;
    bus.ucode_done_i  = 1'b0;
    bus.ucode_accum_i = 1'b0;
    bus.upd_ready_i   = 1'b1;
    tick();
    tick();
    chk("reset_outs", outs(), 8'h00);
    chk("reset_iter", bus.iter_cnt_o, 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // three iterations, ready always high, done with the third valid
    start_job();
    chk("run_state", dbg_state, 2);
    run_iter(4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    run_iter(4, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1);
    run_iter(4, 1'b0, 1'b0, 1'b1, 0, 1'b1, 2);
    chk("finish_outs", outs(), CLR | EVT | BSY);
    tick();
    chk("idle_after_job", outs(), 8'h00);
    chk("idle_iter_kept", bus.iter_cnt_o, 3);
    tick();
    chk("no_second_evt", outs(), 8'h00);

    // backpressure for 5 cycles, done pulse one cycle ahead of valid
    start_job();
    run_iter(3, 1'b1, 1'b1, 1'b0, 5, 1'b1, 0);
    chk("bp_finish", outs(), CLR | EVT | BSY);
    tick();
    chk("bp_idle", outs(), 8'h00);
    chk("bp_iter", bus.iter_cnt_o, 1);

    // watchdog: eight enables with no valid
    start_job();
    for (int i = 0; i < 8; i++) begin
      chk("wd_enable", outs(), EN | BSY);
      tick();
    end
    chk("wd_trip", outs(), CLR | ERR);
    chk("wd_state", dbg_state, 0);
    tick();
    chk("wd_sticky", outs(), ERR);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("wd_err_cleared", outs(), CLR | BSY);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("abort_in_clear", outs(), CLR);
    tick();
    chk("abort_in_clear_idle", outs(), 8'h00);

    // abort while the streamers hold off ready
    start_job();
    chk("ab_run0", outs(), EN | BSY);
    tick();
    bus.ucode_valid_i = 1'b1;
    bus.ucode_accum_i = 1'b1;
    bus.upd_ready_i   = 1'b0;
    tick();
    bus.ucode_valid_i = 1'b0;
    bus.ucode_accum_i = 1'b0;
    chk("ab_handoff", outs(), UV | ACC | BSY);
    tick();
    chk("ab_handoff_hold", outs(), UV | ACC | BSY);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("ab_clear", outs(), CLR);
    chk("ab_iter", bus.iter_cnt_o, 0);
    tick();
    chk("ab_idle", outs(), 8'h00);
    bus.upd_ready_i = 1'b1;

    // abort alone in IDLE is ignored; start with abort in IDLE starts a job
    bus.abort_i = 1'b1;
    tick();
    chk("idle_abort_ignored", outs(), 8'h00);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    chk("start_beats_abort", outs(), CLR | BSY);
    tick();
    bus.start_i = 1'b1;
    #1;
    chk("busy_start_run", outs(), EN | BSY);
    tick();
    bus.start_i = 1'b0;
    chk("busy_start_ignored", outs(), EN | BSY);
    tick();

    // reset in the middle of a job
    run_iter(2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    chk("pre_reset_run", outs(), EN | BSY);
    rst = 1'b1;
    tick();
    chk("midrun_reset_outs", outs(), 8'h00);
    chk("midrun_reset_iter", bus.iter_cnt_o, 0);
    chk("midrun_reset_state", dbg_state, 0);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", outs(), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
